keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Input-side counterpart to the hex display controller. It scans a 4x4 active-low matrix keypad by driving columns and reading rows.
- Debounces the key, encodes it as a 4-bit hex digit, and emits a one-cycle VALID strobe per accepted press.
- Optionally keeps a 4-digit shift register whose outputs feed the display controller's D0..D3 directly.

Parameters:
- SCAN_DIV, 131072, CLK cycles per scan tick (matches ~ladder[17] rate); must be >= 2
- DEBOUNCE_CNT, 4, consecutive agreeing ticks needed to accept a press or a release; 1..15

Ports:
- CLK  input  1  system clock
- CLEAR  input  1  asynchronous active-low reset
- ROW  input  4  keypad rows, active-low (pulled up externally), asynchronous to CLK
- COL  output  4  column drive, active-low, exactly one bit low at all times
- KEY  output  4  hex code of last accepted key
- VALID  output  1  one-cycle strobe, KEY newly updated
- PRESSED  output  1  high while an accepted key is held (HELD state)

Behaviour:
- Reset (CLEAR=0, async) puts the block in this state:
  - COL=4'b1110, KEY=0, VALID=0, PRESSED=0
  - state=SCAN, divider=0, debounce count=0, captured code=0
- ROW passes through a 2-flop synchronizer (rsync). All decisions use rsync.
- Divider counts 0..SCAN_DIV-1 and wraps. tick=1 for one cycle when divider==SCAN_DIV-1.
- Column index c (0..3) selects the low bit of COL. Only SCAN advances c, at a tick, after sampling.
- Row index r: the lowest-index low bit of rsync. Multiple rows low gives the lowest r; other rows are ignored.
- Key map (row r, col c -> KEY):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: *=E, 0=0, #=F, D
- State SCAN, at tick:
  - If rsync != 4'hF: capture (r,c), count=1, go DEBOUNCE. c is frozen.
  - Else: c = c+1 mod 4.
- State DEBOUNCE, at tick:
  - If rsync != 4'hF and the row equals the captured r: count++.
  - When count reaches DEBOUNCE_CNT, in that same tick:
    - KEY <= mapped code, VALID <= 1 (registered, high the cycle after the tick)
    - PRESSED <= 1, count=0, go HELD
  - Otherwise (no row, or different row): count=0, go SCAN; c advances normally.
  - DEBOUNCE_CNT=1 accepts at the detecting tick: SCAN goes straight to HELD with VALID.
- State HELD, column frozen, at tick:
  - If rsync==4'hF: count++. Else count=0 (bounce or still held).
  - When count reaches DEBOUNCE_CNT: PRESSED <= 0, count=0, go SCAN; c advances at the next SCAN tick.
- VALID is exactly one CLK cycle per press, and no repeat while held.
- Latency: VALID rises one cycle after the (DEBOUNCE_CNT-1)-th tick following the detecting tick.
- Reset mid-operation: immediate return to the reset values; a partial press is discarded with no VALID.
- A second key pressed in another column while HELD is ignored until release.

Optional Feature:
- Macro: KEYPAD_SHIFT_DIGITS_EN.
- When defined, outputs D0, D1, D2, D3 (4 bits each) are added:
  - On each VALID: D3<=D2, D2<=D1, D1<=D0, D0<=KEY (new).
  - If KEY==4'hE (*), all four clear to 0 instead of shifting.
  - Reset value of D0..D3 is 0.
- When undefined, these ports and their registers do not exist. All other behaviour is identical.

Decomposition:
- Package keypad_pkg holds:
  - typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} kp_state_t
  - localparam COL_IDLE=4'b1110, ROWS_NONE=4'hF
  - function key_map(r,c) returning the 4-bit code table
- One sub-module: scan_divider (parameter SCAN_DIV; ports CLK, CLEAR, tick). The top instantiates it.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3):
- Reset release, no key -> COL cycles 1110,1101,1011,0111,1110, changing every 4 CLKs; VALID never high.
- Hold ROW=1101 only while COL=1011 (key 6) -> VALID one cycle with KEY=6, PRESSED=1, COL frozen at 1011. On release, PRESSED=0 after 3 released ticks and scanning resumes.
- Press key 5 for 1 tick, then release (bounce) -> no VALID; FSM back in SCAN; KEY unchanged.
- ROW=1100 with COL=1110 -> KEY=1 (row 0 wins), single VALID; holding 20 ticks produces no further VALID.
- Assert CLEAR=0 mid-DEBOUNCE -> all outputs return to reset values at once; no VALID after release of reset with keys up.
- KEYPAD_SHIFT_DIGITS_EN: press 1,2,3 -> D3..D0 = 0,1,2,3; then press * -> all D=0.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, constants and the key code table for keypad_scanner.
//   kp_state_t : scanner FSM state
//   COL_IDLE   : column drive after reset (column 0 selected)
//   ROWS_NONE  : synchronized row value with no key down
//   key_map()  : (row, col) -> 4-bit hex key code
//   row_index(): lowest-index active-low row
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } kp_state_t;

   localparam logic [3:0] COL_IDLE  = 4'b1110;
   localparam logic [3:0] ROWS_NONE = 4'hF;

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'b00_00: code = 4'h1;
         4'b00_01: code = 4'h2;
         4'b00_10: code = 4'h3;
         4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h6;
         4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;
         4'b10_01: code = 4'h8;
         4'b10_10: code = 4'h9;
         4'b10_11: code = 4'hC;
         4'b11_00: code = 4'hE;   // '*'
         4'b11_01: code = 4'h0;
         4'b11_10: code = 4'hF;   // '#'
         default:  code = 4'hD;
      endcase
      return code;
   endfunction

   // Several rows low at once: the lowest index wins.
   function automatic logic [1:0] row_index(input logic [3:0] rows);
      logic [1:0] r;
      if (!rows[0])      r = 2'd0;
      else if (!rows[1]) r = 2'd1;
      else if (!rows[2]) r = 2'd2;
      else               r = 2'd3;
      return r;
   endfunction

endpackage

// File: rtl/keypad_scanner_scan_divider.sv
// scan_divider: free-running divider producing the keypad scan tick.
//   CLK   : system clock
//   CLEAR : asynchronous active-low reset
//   tick  : high for one CLK cycle when the divider is at SCAN_DIV-1
module scan_divider #(
   parameter int SCAN_DIV = 131072
) (
   input  logic CLK,
   input  logic CLEAR,
   output logic tick
);

   localparam int W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

   logic [W-1:0] div_cnt;

   always_ff @(posedge CLK or negedge CLEAR) begin
      if (!CLEAR)              div_cnt <= '0;
      else if (div_cnt == LAST) div_cnt <= '0;
      else                     div_cnt <= div_cnt + 1'b1;
   end

   assign tick = (div_cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner with debounce.
//   CLK     : system clock
//   CLEAR   : asynchronous active-low reset
//   ROW     : keypad rows, active-low, asynchronous to CLK
//   COL     : column drive, active-low, one bit low at all times
//   KEY     : hex code of the last accepted key
//   VALID   : one-cycle strobe when KEY has just been updated
//   PRESSED : high while an accepted key is held
//   D0..D3  : 4-digit shift register of accepted keys ('*' clears),
//             present only when KEYPAD_SHIFT_DIGITS_EN is defined
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SCAN     | walking columns, one per tick, waiting for any row low
// DEBOUNCE | column frozen, counting ticks the same row stays low
// HELD     | key accepted, column frozen, counting released ticks
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 131072,
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic       CLK,
   input  logic       CLEAR,
   input  logic [3:0] ROW,
   output logic [3:0] COL,
   output logic [3:0] KEY,
   output logic       VALID,
   output logic       PRESSED
`ifdef KEYPAD_SHIFT_DIGITS_EN
   ,
   output logic [3:0] D0,
   output logic [3:0] D1,
   output logic [3:0] D2,
   output logic [3:0] D3
`endif
);

   localparam logic [3:0] DB = 4'(DEBOUNCE_CNT);

   logic       tick;
   logic [3:0] rsync_meta;
   logic [3:0] rsync;
   kp_state_t  state;
   logic [1:0] col_idx;
   logic [3:0] cnt;
   logic [1:0] cap_r;

   logic       row_hit;
   logic [1:0] cur_r;
   logic [3:0] cnt_inc;
   logic       accept;
   logic [3:0] acc_key;

   scan_divider #(.SCAN_DIV(SCAN_DIV)) u_div (
      .CLK   (CLK),
      .CLEAR (CLEAR),
      .tick  (tick)
   );

   always_ff @(posedge CLK or negedge CLEAR) begin
      if (!CLEAR) begin
         rsync_meta <= ROWS_NONE;
         rsync      <= ROWS_NONE;
      end else begin
         rsync_meta <= ROW;
         rsync      <= rsync_meta;
      end
   end

   // In DEBOUNCE an accept requires cur_r == cap_r, so cur_r is the
   // accepted row in both accept paths.
   always_comb begin
      row_hit = (rsync != ROWS_NONE);
      cur_r   = row_index(rsync);
      cnt_inc = cnt + 4'd1;
      acc_key = key_map(cur_r, col_idx);
      accept  = 1'b0;
      if (tick && row_hit) begin
         if (state == SCAN && DB == 4'd1)
            accept = 1'b1;
         else if (state == DEBOUNCE && cur_r == cap_r && cnt_inc == DB)
            accept = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge CLEAR) begin
      if (!CLEAR) begin
         state   <= SCAN;
         COL     <= COL_IDLE;
         col_idx <= 2'd0;
         cnt     <= 4'd0;
         cap_r   <= 2'd0;
         KEY     <= 4'd0;
         VALID   <= 1'b0;
         PRESSED <= 1'b0;
      end else begin
         VALID <= 1'b0;
         if (accept) begin
            KEY     <= acc_key;
            VALID   <= 1'b1;
            PRESSED <= 1'b1;
            cnt     <= 4'd0;
            state   <= HELD;
         end else if (tick) begin
            case (state)
               SCAN: begin
                  if (row_hit) begin
                     cap_r <= cur_r;
                     cnt   <= 4'd1;
                     state <= DEBOUNCE;
                  end else begin
                     COL     <= {COL[2:0], COL[3]};
                     col_idx <= col_idx + 2'd1;
                  end
               end
               DEBOUNCE: begin
                  if (row_hit && cur_r == cap_r) begin
                     cnt <= cnt_inc;
                  end else begin
                     cnt   <= 4'd0;
                     state <= SCAN;
                  end
               end
               HELD: begin
                  if (row_hit) begin
                     cnt <= 4'd0;
                  end else if (cnt_inc == DB) begin
                     PRESSED <= 1'b0;
                     cnt     <= 4'd0;
                     state   <= SCAN;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               default: state <= SCAN;
            endcase
         end
      end
   end

`ifdef KEYPAD_SHIFT_DIGITS_EN
   always_ff @(posedge CLK or negedge CLEAR) begin
      if (!CLEAR) begin
         D0 <= 4'd0;
         D1 <= 4'd0;
         D2 <= 4'd0;
         D3 <= 4'd0;
      end else if (accept) begin
         if (acc_key == 4'hE) begin
            D0 <= 4'd0;
            D1 <= 4'd0;
            D2 <= 4'd0;
            D3 <= 4'd0;
         end else begin
            D3 <= D2;
            D2 <= D1;
            D1 <= D0;
            D0 <= acc_key;
         end
      end
   end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DB = 3;

   logic       CLK = 1'b0;
   logic       CLEAR;
   logic [3:0] ROW;
   logic [3:0] COL;
   logic [3:0] KEY;
   logic       VALID;
   logic       PRESSED;
`ifdef KEYPAD_SHIFT_DIGITS_EN
   logic [3:0] D0, D1, D2, D3;
`endif

   always #5 CLK = ~CLK;

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
      .CLK     (CLK),
      .CLEAR   (CLEAR),
      .ROW     (ROW),
      .COL     (COL),
      .KEY     (KEY),
      .VALID   (VALID),
      .PRESSED (PRESSED)
`ifdef KEYPAD_SHIFT_DIGITS_EN
      ,
      .D0      (D0),
      .D1      (D1),
      .D2      (D2),
      .D3      (D3)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;
   int vcnt     = 0;

   bit keys [4][4];
   int kmap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

   // reference model: phase 0 = walking, 1 = confirming, 2 = waiting for release
   int         m_div, m_phase, m_col, m_cnt, m_row;
   logic [3:0] m_s1, m_s2, m_key;
   bit         m_valid, m_pressed;

   typedef struct {
      int         r;
      int         c;
      logic [3:0] exp;
   } vec_t;
   vec_t tbl [16];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] rows_from(input logic [3:0] col);
      logic [3:0] rows;
      rows = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r][c] && !col[c]) rows[r] = 1'b0;
      return rows;
   endfunction

   function automatic int first_low(input logic [3:0] v);
      for (int i = 0; i < 4; i++)
         if (!v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_div = 0; m_phase = 0; m_col = 0; m_cnt = 0; m_row = 0;
      m_s1 = 4'hF; m_s2 = 4'hF; m_key = 4'd0;
      m_valid = 0; m_pressed = 0;
   endtask

   task automatic model_clock();
      bit         tk;
      int         r;
      tk = (m_div == SD - 1);
      m_div = (m_div + 1) % SD;
      r = first_low(m_s2);
      m_s2 = m_s1;
      m_s1 = ROW;
      m_valid = 0;
      if (!tk) return;
      if (m_phase == 0) begin
         if (r >= 0) begin
            m_row = r;
            m_cnt = 1;
            m_phase = 1;
         end else begin
            m_col = (m_col + 1) % 4;
         end
      end else if (m_phase == 1) begin
         if (r == m_row) m_cnt++;
         else begin m_cnt = 0; m_phase = 0; end
      end else begin
         if (r < 0) m_cnt++;
         else m_cnt = 0;
         if (m_cnt == DB) begin m_pressed = 0; m_cnt = 0; m_phase = 0; end
      end
      if (m_phase == 1 && m_cnt == DB) begin
         m_key = 4'(kmap[m_row][m_col]);
         m_valid = 1;
         m_pressed = 1;
         m_cnt = 0;
         m_phase = 2;
      end
   endtask

   task automatic set_rows();
      ROW = rows_from(COL);
   endtask

   task automatic step();
      @(posedge CLK);
      if (!CLEAR) model_reset();
      else model_clock();
      #1;
      ROW = rows_from(COL);
      @(negedge CLK);
      check("col", COL, 4'hF & ~(4'b0001 << m_col));
      check("key", KEY, m_key);
      check("valid", VALID, m_valid);
      check("pressed", PRESSED, m_pressed);
      if (VALID) vcnt++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic release_all();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            keys[r][c] = 0;
      set_rows();
   endtask

   task automatic wait_valid(input string name, input int bound);
      bit got;
      got = 0;
      for (int i = 0; i < bound && !got; i++) begin
         step();
         if (VALID) got = 1;
      end
      check(name, got, 1);
   endtask

   task automatic wait_released(input string name, input int bound);
      bit got;
      got = 0;
      for (int i = 0; i < bound && !got; i++) begin
         step();
         if (!PRESSED) got = 1;
      end
      check(name, got, 1);
   endtask

   task automatic wait_confirming(input string name, input int bound);
      bit got;
      got = 0;
      for (int i = 0; i < bound && !got; i++) begin
         step();
         if (m_phase == 1) got = 1;
      end
      check(name, got, 1);
   endtask

   task automatic press(input int r, input int c);
      release_all();
      keys[r][c] = 1;
      set_rows();
      wait_valid("press_valid", 200);
      release_all();
      wait_released("press_release", 200);
   endtask

   initial begin
      int v0;
      tbl[0]  = '{0, 0, 4'h1}; tbl[1]  = '{0, 1, 4'h2}; tbl[2]  = '{0, 2, 4'h3}; tbl[3]  = '{0, 3, 4'hA};
      tbl[4]  = '{1, 0, 4'h4}; tbl[5]  = '{1, 1, 4'h5}; tbl[6]  = '{1, 2, 4'h6}; tbl[7]  = '{1, 3, 4'hB};
      tbl[8]  = '{2, 0, 4'h7}; tbl[9]  = '{2, 1, 4'h8}; tbl[10] = '{2, 2, 4'h9}; tbl[11] = '{2, 3, 4'hC};
      tbl[12] = '{3, 0, 4'hE}; tbl[13] = '{3, 1, 4'h0}; tbl[14] = '{3, 2, 4'hF}; tbl[15] = '{3, 3, 4'hD};

      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            keys[r][c] = 0;
      ROW = 4'hF;
      CLEAR = 1'b1;
      model_reset();
      #2 CLEAR = 1'b0;
      run(3);
      check("rst_col", COL, 4'b1110);
      check("rst_key", KEY, 0);
      check("rst_valid", VALID, 0);
      check("rst_pressed", PRESSED, 0);

      // column walk after reset release, no key
      CLEAR = 1'b1;
      vcnt = 0;
      for (int i = 1; i <= 16; i++) begin
         step();
         if (i == 3)  check("walk_c0", COL, 4'b1110);
         if (i == 4)  check("walk_c1", COL, 4'b1101);
         if (i == 8)  check("walk_c2", COL, 4'b1011);
         if (i == 12) check("walk_c3", COL, 4'b0111);
         if (i == 16) check("walk_wrap", COL, 4'b1110);
      end
      run(20);
      check("idle_no_valid", vcnt, 0);

      // key 6: accept, hold without repeat, release
      keys[1][2] = 1;
      set_rows();
      wait_valid("k6_valid", 200);
      check("k6_key", KEY, 6);
      check("k6_pressed", PRESSED, 1);
      check("k6_col_frozen", COL, 4'b1011);
      v0 = vcnt;
      run(40);
      check("k6_no_repeat", vcnt - v0, 0);
      check("k6_col_held", COL, 4'b1011);
      release_all();
      wait_released("k6_release", 30);

      // key 5 seen for one tick only: bounce
      keys[1][1] = 1;
      set_rows();
      wait_confirming("k5_detect", 200);
      release_all();
      v0 = vcnt;
      run(40);
      check("bounce_no_valid", vcnt - v0, 0);
      check("bounce_key_kept", KEY, 6);
      check("bounce_not_pressed", PRESSED, 0);

      // rows 0 and 1 both low in column 0: row 0 wins, held 20 ticks
      keys[0][0] = 1;
      keys[1][0] = 1;
      set_rows();
      wait_valid("multi_valid", 200);
      check("multi_key", KEY, 1);
      v0 = vcnt;
      run(20 * SD);
      check("multi_no_repeat", vcnt - v0, 0);
      // second key in another column while held is ignored
      keys[2][3] = 1;
      run(10 * SD);
      check("held_other_ignored", vcnt - v0, 0);
      check("held_key", KEY, 1);
      release_all();
      wait_released("multi_release", 60);

      // reset during debounce
      keys[0][1] = 1;
      set_rows();
      wait_confirming("clr_detect", 200);
      CLEAR = 1'b0;
      #1;
      check("clr_col", COL, 4'b1110);
      check("clr_key", KEY, 0);
      check("clr_valid", VALID, 0);
      check("clr_pressed", PRESSED, 0);
      model_reset();
      release_all();
      run(3);
      CLEAR = 1'b1;
      v0 = vcnt;
      run(40);
      check("clr_no_valid", vcnt - v0, 0);

      // every key position
      for (int i = 0; i < 16; i++) begin
         release_all();
         keys[tbl[i].r][tbl[i].c] = 1;
         set_rows();
         wait_valid("tbl_valid", 200);
         check("tbl_key", KEY, tbl[i].exp);
         release_all();
         wait_released("tbl_release", 60);
      end

`ifdef KEYPAD_SHIFT_DIGITS_EN
      press(3, 0);
      press(0, 0);
      press(0, 1);
      press(0, 2);
      check("dig_d3", D3, 0);
      check("dig_d2", D2, 1);
      check("dig_d1", D1, 2);
      check("dig_d0", D0, 3);
      press(3, 0);
      check("dig_clr", {D3, D2, D1, D0}, 0);
`endif

      // randomized presses, bounces and overlapping keys against the model
      for (int it = 0; it < 50; it++) begin
         int k;
         release_all();
         k = $urandom_range(0, 15);
         keys[k / 4][k % 4] = 1;
         if ($urandom_range(0, 3) == 0) begin
            k = $urandom_range(0, 15);
            keys[k / 4][k % 4] = 1;
         end
         set_rows();
         run($urandom_range(1, 60));
         release_all();
         run($urandom_range(1, 60));
      end
      release_all();
      run(60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
